// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader for the instruction memory.
// Accepts a framed stream (LEN_LO, LEN_HI, 4*N data bytes LSB-first, CHK),
// writes the assembled words to consecutive word addresses and holds the
// core stalled until the image and its XOR checksum have been accepted.
//
// Ports:
//   clk, rst             rising-edge clock, async active-high reset
//   in_valid/in_data     byte stream, transfers when in_valid & in_ready
//   in_ready             decoded from state; high in every loading state
//   rom_we/addr/wdata    registered one-cycle write to instruction memory
//   cpu_run              image loaded and checksum matched
//   error                sticky failure (bad length or checksum)
//   busy                 load still in progress
module imem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [31:0]       rom_wdata,
  output logic              cpu_run,
  output logic              error,
  output logic              busy
);

  typedef enum logic [2:0] {S_LEN0, S_LEN1, S_DATA, S_CHK, S_DONE, S_ERR} state_t;

  localparam logic [31:0] MAX_N = 32'(1) << ADDR_W;

  state_t          state, nxt;
  logic [15:0]     len;
  logic [1:0]      bcnt;
  logic [7:0]      xsum;
  // One extra bit so a full 2^ADDR_W image counts to completion without wrap.
  logic [ADDR_W:0] widx, widx_inc;
  logic            acc, last_word;
  logic [31:0]     n_new;
  logic [23:0]     low_bytes;

  assign in_ready  = (state == S_LEN0) || (state == S_LEN1) ||
                     (state == S_DATA) || (state == S_CHK);
  assign acc       = in_valid & in_ready;
  assign n_new     = 32'({in_data, len[7:0]});
  assign widx_inc  = widx + 1'b1;
  assign last_word = (32'(widx_inc) == 32'(len));

  // Byte lanes 0..2 hold the first three bytes of a word; lane 3 is taken
  // straight from in_data when the word completes.
  for (genvar g = 0; g < 3; g++) begin : g_lane
    logic [7:0] q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                                        q <= '0;
      else if (acc && state == S_DATA && bcnt == 2'(g)) q <= in_data;
    end
  end
  assign low_bytes = {g_lane[2].q, g_lane[1].q, g_lane[0].q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_LEN0;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_LEN0: if (acc) nxt = S_LEN1;
      S_LEN1: if (acc) begin
        if (n_new > MAX_N)      nxt = S_ERR;
        else if (n_new == '0)   nxt = S_CHK;
        else                    nxt = S_DATA;
      end
      S_DATA: if (acc && bcnt == 2'd3 && last_word) nxt = S_CHK;
      S_CHK:  if (acc) nxt = (in_data == xsum) ? S_DONE : S_ERR;
      default: nxt = state;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len       <= '0;
      bcnt      <= '0;
      xsum      <= '0;
      widx      <= '0;
      rom_we    <= 1'b0;
      rom_addr  <= '0;
      rom_wdata <= '0;
      cpu_run   <= 1'b0;
      error     <= 1'b0;
      busy      <= 1'b1;
    end else begin
      rom_we  <= 1'b0;
      // Status follows the next state so it changes on the CHK edge itself.
      cpu_run <= (nxt == S_DONE);
      error   <= (nxt == S_ERR);
      busy    <= (nxt != S_DONE) && (nxt != S_ERR);
      if (acc) begin
        case (state)
          S_LEN0: len[7:0]  <= in_data;
          S_LEN1: len[15:8] <= in_data;
          S_DATA: begin
            xsum <= xsum ^ in_data;
            bcnt <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
              rom_we    <= 1'b1;
              rom_addr  <= widx[ADDR_W-1:0];
              rom_wdata <= {in_data, low_bytes};
              widx      <= widx_inc;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed bench for imem_loader. A frame parser model
// derives expected writes and final status from the raw byte frame; a
// negedge monitor matches every rom_we pulse against the expected queue.
module tb_imem_loader;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = '0;
  logic              in_ready, rom_we, cpu_run, error, busy;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_wdata;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .rom_we(rom_we), .rom_addr(rom_addr),
    .rom_wdata(rom_wdata), .cpu_run(cpu_run), .error(error), .busy(busy)
  );

  always #5 clk = ~clk;

  int          checks = 0, failures = 0;
  logic [47:0] expq[$];      // {16'addr, 32'data}
  logic [7:0]  frame[$];
  logic [31:0] words[$];
  logic [31:0] last_addr, last_data;
  int          nwrites;
  logic        exp_run, exp_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Write monitor: each rom_we cycle must match the next expected write.
  always @(negedge clk) begin
    if (!rst && rom_we) begin
      logic [47:0] e;
      nwrites++;
      last_addr = 32'(rom_addr);
      last_data = rom_wdata;
      if (expq.size() == 0) chk("rom_we_unexpected", 1, 0);
      else begin
        e = expq.pop_front();
        chk("rom_addr", 64'(rom_addr), 64'(e[47:32]));
        chk("rom_wdata", 64'(rom_wdata), 64'(e[31:0]));
      end
    end
  end

  // Present one byte from a negedge; in_ready is stable through the low
  // phase, so seeing it high here means the byte transfers on the next edge.
  task automatic send(input logic [7:0] b, input bit thr);
    int t = 0;
    if (thr) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("send_timeout", 1, 0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // One-cycle valid pulse regardless of in_ready (for bytes that must be ignored).
  task automatic poke(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset(input bit check_outs);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    if (check_outs) begin
      chk("rst_in_ready", 64'(in_ready), 1);
      chk("rst_rom_we", 64'(rom_we), 0);
      chk("rst_rom_addr", 64'(rom_addr), 0);
      chk("rst_rom_wdata", 64'(rom_wdata), 0);
      chk("rst_cpu_run", 64'(cpu_run), 0);
      chk("rst_error", 64'(error), 0);
      chk("rst_busy", 64'(busy), 1);
    end
    expq.delete();
    nwrites = 0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Frame from the words queue; chk_flip corrupts the checksum byte.
  task automatic build(input logic [7:0] chk_flip);
    logic [7:0] x = '0;
    frame.delete();
    frame.push_back(8'(words.size()));
    frame.push_back(8'(words.size() >> 8));
    foreach (words[i]) for (int j = 0; j < 4; j++) begin
      frame.push_back(words[i][8*j +: 8]);
      x ^= words[i][8*j +: 8];
    end
    frame.push_back(x ^ chk_flip);
  endtask

  // Model: parse the frame, queue expected writes, decide the outcome, then
  // stream the bytes the loader should consume and poke the rest.
  task automatic run_frame(input bit thr);
    int n, used;
    logic [7:0] x = '0;
    n = int'({frame[1], frame[0]});
    if (n > (1 << ADDR_W)) begin
      exp_err = 1'b1;
      exp_run = 1'b0;
      used = 2;
    end else begin
      for (int k = 0; k < n; k++) begin
        logic [31:0] w;
        for (int j = 0; j < 4; j++) begin
          w[8*j +: 8] = frame[2 + 4*k + j];
          x ^= frame[2 + 4*k + j];
        end
        expq.push_back({16'(k), w});
      end
      used = 2 + 4*n + 1;
      exp_run = (frame[used-1] == x);
      exp_err = !exp_run;
    end
    for (int i = 0; i < frame.size(); i++) begin
      if (i < used) send(frame[i], thr);
      else          poke(frame[i]);
    end
    repeat (2) @(negedge clk);
    chk("pending_writes", 64'(expq.size()), 0);
    chk("cpu_run", 64'(cpu_run), 64'(exp_run));
    chk("error", 64'(error), 64'(exp_err));
    chk("in_ready_final", 64'(in_ready), 0);
    chk("busy_final", 64'(busy), 0);
  endtask

  initial begin
    nwrites = 0;
    do_reset(1'b1);

    // Single word, back-to-back; CHK arrives during the rom_we cycle.
    frame = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
    expq.push_back({16'd0, 32'h12345678});
    for (int i = 0; i < 6; i++) send(frame[i], 1'b0);
    chk("chk_cycle_rom_we", 64'(rom_we), 1);
    chk("chk_cycle_in_ready", 64'(in_ready), 1);
    send(frame[6], 1'b0);
    chk("single_cpu_run", 64'(cpu_run), 1);
    chk("single_error", 64'(error), 0);
    chk("single_busy", 64'(busy), 0);
    chk("single_nwrites", 64'(nwrites), 1);
    chk("single_last_data", 64'(last_data), 64'h12345678);

    // Throttled three-word image.
    do_reset(1'b0);
    words = '{32'h00000013, 32'hFFFFFFFF, 32'h80000001};
    build(8'h00);
    chk("throttle_chk_byte", 64'(frame[14]), 64'h92);
    run_frame(1'b1);
    chk("throttle_nwrites", 64'(nwrites), 3);
    chk("throttle_last_data", 64'(last_data), 64'h80000001);

    // Bad checksum, trailing bytes ignored.
    do_reset(1'b0);
    frame = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_frame(1'b0);
    chk("badchk_error", 64'(error), 1);
    chk("badchk_nwrites", 64'(nwrites), 1);

    // Empty image.
    do_reset(1'b0);
    frame = '{8'h00, 8'h00, 8'h00};
    run_frame(1'b0);
    chk("empty_nwrites", 64'(nwrites), 0);

    // Oversize length: error straight after LEN_HI.
    do_reset(1'b0);
    frame = '{8'h01, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
    run_frame(1'b0);
    chk("oversize_error", 64'(error), 1);
    chk("oversize_nwrites", 64'(nwrites), 0);

    // Full 1024-word image.
    do_reset(1'b0);
    words.delete();
    for (int i = 0; i < 1024; i++) words.push_back($urandom());
    build(8'h00);
    run_frame(1'b0);
    chk("full_nwrites", 64'(nwrites), 1024);
    chk("full_last_addr", 64'(last_addr), 1023);

    // Reset two bytes into word 1, then load a fresh single word.
    do_reset(1'b0);
    frame = '{8'h02, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'hEE, 8'hFF};
    expq.push_back({16'd0, 32'h11223344});
    foreach (frame[i]) send(frame[i], 1'b0);
    chk("midrst_pending", 64'(expq.size()), 0);
    do_reset(1'b1);
    words = '{32'hAABBCCDD};
    build(8'h00);
    run_frame(1'b0);
    chk("midrst_last_addr", 64'(last_addr), 0);
    chk("midrst_last_data", 64'(last_data), 64'hAABBCCDD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
